// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM duty scheduler: FSM state encoding and size defaults.
// Optional build macro used by the design: PWM_CENTER_ALIGNED_EN.
package pwm_pkg;

  localparam int PWM_WIDTH_DEFAULT  = 11;
  localparam int PWM_PERIOD_DEFAULT = 2047;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } pwm_state_t;

endpackage

// File: rtl/pwm_carrier_counter.sv
// Carrier counter with wrap detect; advances every cycle while run=1, held at 0 otherwise.
// Edge-aligned 0..PERIOD by default; PWM_CENTER_ALIGNED_EN selects up/down counting (period 2*PERIOD).
module pwm_carrier_counter
  import pwm_pkg::*;
#(
  parameter int WIDTH  = PWM_WIDTH_DEFAULT,
  parameter int PERIOD = PWM_PERIOD_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  output logic [WIDTH-1:0] cnt,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] PMAX = WIDTH'(PERIOD);

`ifdef PWM_CENTER_ALIGNED_EN
  logic down;

  // Wrap is the down-slope 1->0 step; with PERIOD=1 there is no down slope, so wrap from the top.
  assign wrap = (cnt == WIDTH'(1)) && (down || (PMAX == WIDTH'(1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      down <= 1'b0;
    end else if (!run || wrap) begin
      cnt  <= '0;
      down <= 1'b0;
    end else if (!down && (cnt == PMAX)) begin
      cnt  <= PMAX - 1'b1;
      down <= 1'b1;
    end else if (down) begin
      cnt <= cnt - 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
`else
  assign wrap = (cnt == PMAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!run || wrap) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
`endif

endmodule

// File: rtl/pwm_duty_scheduler.sv
// PWM with double-buffered duty (shadow -> active at period wrap); pwm_out lags cmp_c by 1 cycle.
// s_ready is low while the shadow holds an unapplied sample; center-aligned mode via PWM_CENTER_ALIGNED_EN.
module pwm_duty_scheduler
  import pwm_pkg::*;
#(
  parameter int WIDTH  = PWM_WIDTH_DEFAULT,
  parameter int PERIOD = PWM_PERIOD_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             s_valid,
  input  logic [WIDTH-1:0] s_data,
  output logic             s_ready,
  output logic [WIDTH-1:0] cmp_r,
  output logic [WIDTH-1:0] cmp_c,
  output logic             pwm_out,
  output logic             period_start,
  output logic             underrun,
  output logic             busy
);

  localparam logic [WIDTH-1:0] PMAX = WIDTH'(PERIOD);

  pwm_state_t       state;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] duty_active;
  logic [WIDTH-1:0] shadow;
  logic [WIDTH-1:0] s_data_sat;
  logic             shadow_full;
  logic             wrap;
  logic             running;
  logic             start;
  logic             xfer;

  assign running    = (state != IDLE);
  // A new period begins on leaving IDLE or on a wrap that is not ending the run.
  assign start      = en && (!running || wrap);
  assign xfer       = s_valid && !shadow_full;
  assign s_data_sat = (s_data > PMAX) ? PMAX : s_data;

  assign s_ready = !shadow_full;
  assign cmp_r   = duty_active;
  assign cmp_c   = cnt;
  assign busy    = running;

  pwm_carrier_counter #(
    .WIDTH  (WIDTH),
    .PERIOD (PERIOD)
  ) u_carrier (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (running),
    .cnt   (cnt),
    .wrap  (wrap)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      duty_active  <= '0;
      shadow       <= '0;
      shadow_full  <= 1'b0;
      pwm_out      <= 1'b0;
      period_start <= 1'b0;
      underrun     <= 1'b0;
    end else begin
      pwm_out      <= running && (cnt < duty_active);
      period_start <= start;
      underrun     <= start && !shadow_full;

      // A sample accepted on a start cycle is only seen by the next start.
      if (start && shadow_full) begin
        duty_active <= shadow;
        shadow_full <= 1'b0;
      end else if (xfer) begin
        shadow      <= s_data_sat;
        shadow_full <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (en) state <= RUN;
        end
        RUN: begin
          if (!en) state <= wrap ? IDLE : DRAIN;
        end
        DRAIN: begin
          if (en)        state <= RUN;
          else if (wrap) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
